// File: rtl/pu_mat_vec.sv
// pu_mat_vec: parallel matrix-column / vector multiply-accumulate unit.
//
// One operation runs MATRIX_COL accumulation steps. On each step a signed
// scalar A is multiplied by every signed lane of B, and each product is
// added to that lane's accumulator. There are MATRIX_ROW lanes and they
// work in parallel. When the last step completes, the final sums go to
// OUT and DONE pulses for one cycle.
//
// Ports:
//   CLK   - sole clock, rising edge
//   RSTN  - synchronous active-high reset (RSTN=1 resets on a CLK edge)
//   START - level request to begin an operation (accepted only in IDLE)
//   A     - signed scalar for the current column
//   B     - packed signed lanes, lane i = B[WIDTH_OP2*i +: WIDTH_OP2]
//   OUT   - packed signed results, lane i = OUT[WIDTH_OUT*i +: WIDTH_OUT]
//   DONE  - one-cycle completion pulse
module pu_mat_vec #(
  parameter int WIDTH_OP1  = 16,
  parameter int WIDTH_OP2  = 16,
  parameter int WIDTH_OUT  = 32,
  parameter int MATRIX_ROW = 8,
  parameter int MATRIX_COL = 16
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            START,
  input  logic [WIDTH_OP1-1:0]            A,
  input  logic [WIDTH_OP2*MATRIX_ROW-1:0] B,
  output logic [WIDTH_OUT*MATRIX_ROW-1:0] OUT,
  output logic                            DONE
);

  localparam int PROD_W = WIDTH_OP1 + WIDTH_OP2;
  localparam int CNT_W  = (MATRIX_COL > 1) ? $clog2(MATRIX_COL) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(MATRIX_COL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [WIDTH_OUT*MATRIX_ROW-1:0]   acc_q, acc_d;
  logic [WIDTH_OUT*MATRIX_ROW-1:0]   out_q, out_d;
  logic                              done_q, done_d;
  logic [WIDTH_OUT*MATRIX_ROW-1:0]   acc_next;
  logic signed [PROD_W-1:0]          prod;

  // Per-lane multiply-accumulate of the current column.
  // Operands are widened before multiplying so the product is the full
  // signed result. It is then sign-extended or truncated to the
  // accumulator width, and the sum wraps.
  always_comb begin
    acc_next = '0;
    prod     = '0;
    for (int i = 0; i < MATRIX_ROW; i++) begin
      prod = PROD_W'($signed(A)) * PROD_W'($signed(B[WIDTH_OP2*i +: WIDTH_OP2]));
      acc_next[WIDTH_OUT*i +: WIDTH_OUT] =
        acc_q[WIDTH_OUT*i +: WIDTH_OUT] + WIDTH_OUT'(prod);
    end
  end

  // Next-state logic for the FSM, the column counter, the accumulators
  // and the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_next;
        if (cnt_q == LAST_COL) begin
          // The last column is done. Publish the sums here, so that OUT
          // never shows a partial result.
          out_d   = acc_next;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = FINISH;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = RUN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        acc_d   = '0;
      end
    endcase
  end

  // State registers. Reset has priority over every other input.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign OUT  = out_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_pu_mat_vec.sv
module tb_pu_mat_vec;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [15:0]  a;
  logic [127:0] b;
  logic [255:0] out_w;
  logic         done;

  pu_mat_vec dut (
    .CLK   (clk),
    .RSTN  (rstn),
    .START (start),
    .A     (a),
    .B     (b),
    .OUT   (out_w),
    .DONE  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  a;
    logic [127:0] b;
    logic [255:0] exp;
    string        name;
  } vec_t;

  int           n_chk  = 0;
  int           n_pass = 0;
  int           n_done = 0;
  logic [255:0] exp_q[$];
  logic [15:0]  col_a [16];
  logic [127:0] col_b [16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Signed dot product per lane over the 16 column arrays, wrapped to 32 bits.
  function automatic logic [255:0] model();
    logic [255:0] r;
    longint       s;
    logic [63:0]  t;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      s = 0;
      for (int c = 0; c < 16; c++)
        s += longint'($signed(col_a[c])) * longint'($signed(col_b[c][16*l +: 16]));
      t = s;
      r[32*l +: 32] = t[31:0];
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int c = 0; c < 16; c++) begin
      col_a[c] = 16'(int'($urandom_range(62)) - 31);
      for (int l = 0; l < 8; l++)
        col_b[c][16*l +: 16] = 16'(int'($urandom_range(62)) - 31);
    end
  endtask

  // Scoreboard side: every DONE pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      check("done_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) check("out_on_done", out_w, exp_q.pop_front());
    end
  end

  // One full operation: the start edge, 16 column edges, then a check that
  // DONE drops. Call it with the FSM in IDLE, at #1 after a posedge.
  task automatic run_op(input logic [255:0] expv, input logic [255:0] prev,
                        input bit keep_start, input string name);
    exp_q.push_back(expv);
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      a = col_a[c];
      b = col_b[c];
      @(posedge clk); #1;
      if (c < 15) begin
        check({name, "_out_hold"}, out_w, prev);
        check({name, "_done_low_run"}, 256'(done), 256'(0));
      end
    end
    check({name, "_done_high"}, 256'(done), 256'(1));
    a = '0;
    b = '0;
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, 256'(done), 256'(0));
  endtask

  vec_t         tbl [4];
  logic [255:0] prev;
  logic [255:0] e1;
  logic [255:0] e2;
  int           nd;

  initial begin
    tbl[0].a = 16'd1;        tbl[0].b = {8{16'd1}};
    tbl[0].exp = {8{32'd16}};                                   tbl[0].name = "ones";
    tbl[1].a = -16'sd3;      tbl[1].b = {-16'sd7, {6{16'd0}}, 16'sd5};
    tbl[1].exp = {32'd336, {6{32'd0}}, 32'hFFFF_FF10};          tbl[1].name = "signed";
    tbl[2].a = 16'h8000;     tbl[2].b = {8{16'h8000}};
    tbl[2].exp = 256'd0;                                       tbl[2].name = "wrap";
    tbl[3].a = 16'sd7;
    tbl[3].b = {16'sd3, 16'sd2, 16'sd1, 16'sd0, -16'sd1, -16'sd2, -16'sd3, -16'sd4};
    tbl[3].exp = {32'd336, 32'd224, 32'd112, 32'd0, -32'sd112, -32'sd224, -32'sd336, -32'sd448};
    tbl[3].name = "mixed";

    rstn  = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset is held for 3 cycles with START low, then for one more cycle with START high.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) start = 1'b1;
      @(posedge clk); #1;
      check("reset_out", out_w, 256'd0);
      check("reset_done", 256'(done), 256'd0);
    end
    start = 1'b0;
    rstn  = 1'b0;
    nd    = n_done;
    repeat (20) @(posedge clk);
    #1;
    check("start_under_reset_ignored", 256'(n_done), 256'(nd));
    check("idle_out_zero", out_w, 256'd0);

    // Table-driven single operations, with the same column values on every step.
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 16; c++) begin
        col_a[c] = tbl[i].a;
        col_b[c] = tbl[i].b;
      end
      run_op(tbl[i].exp, prev, 1'b0, tbl[i].name);
      prev = tbl[i].exp;
    end

    // Random back-to-back operations with START held high.
    fill_random();
    e1 = model();
    run_op(e1, prev, 1'b1, "rand1");
    prev = e1;
    fill_random();
    e2 = model();
    run_op(e2, prev, 1'b0, "rand2");
    prev = e2;

    // Reset arrives after 8 columns: the operation is aborted and no DONE appears.
    fill_random();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a = col_a[c];
      b = col_b[c];
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    check("midrun_reset_out", out_w, 256'd0);
    check("midrun_reset_done", 256'(done), 256'd0);
    rstn = 1'b0;
    nd   = n_done;
    repeat (20) @(posedge clk);
    #1;
    check("midrun_no_done", 256'(n_done), 256'(nd));
    check("midrun_out_stays_zero", out_w, 256'd0);

    fill_random();
    e1 = model();
    run_op(e1, 256'd0, 1'b0, "after_reset");

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 256'(exp_q.size()), 256'd0);
    check("done_pulse_count", 256'(n_done), 256'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
